// File: rtl/scan_chain_ctrl_if.sv
// Handshake bundle between a scan-chain sequencer and its test wrapper / flop chain.
interface scan_chain_ctrl_if #(
   parameter int CHAIN_LEN = 8
);
   logic                 start;
   logic [CHAIN_LEN-1:0] pat;
   logic [CHAIN_LEN-1:0] exp;
   logic                 so;
   logic                 se;
   logic                 si;
   logic [CHAIN_LEN-1:0] resp;
   logic                 busy;
   logic                 done;
   logic                 mismatch;

   modport master (
      input  start, pat, exp, so,
      output se, si, resp, busy, done, mismatch
   );

   modport slave (
      output start, pat, exp, so,
      input  se, si, resp, busy, done, mismatch
   );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan test sequencer: loads a latched pattern into a scan chain, holds functional
// capture for CAPTURE_CYCLES, unloads the response and compares it with the expected value.
module scan_chain_ctrl #(
   parameter int CHAIN_LEN      = 8,
   parameter int CAPTURE_CYCLES = 1
) (
   input  logic              ck,
   input  logic              rst,
   scan_chain_ctrl_if.master bus
);

   localparam int MAX_CNT = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
   localparam int CW      = $clog2(MAX_CNT) + 1;

   localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] SHIFT_END = CW'(CHAIN_LEN - 1);
   localparam logic [CW-1:0] CAP_END   = CW'(CAPTURE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_UNLOAD  = 3'd3,
      ST_FINISH  = 3'd4
   } state_t;

   state_t               state_r;
   state_t               state_s;
   logic [CW-1:0]        cnt_r;
   logic [CW-1:0]        cnt_s;
   logic [CHAIN_LEN-1:0] pat_q_r;
   logic [CHAIN_LEN-1:0] exp_q_r;
   logic [CHAIN_LEN-1:0] resp_r;
   logic                 mismatch_r;
   logic                 se_r;
   logic                 si_r;
   logic                 busy_r;
   logic                 done_r;

   logic                 accept_s;
   logic [CHAIN_LEN-1:0] pat_d_s;
   logic [CHAIN_LEN-1:0] pat_sh_s;
   logic                 si_s;
   logic [CHAIN_LEN-1:0] resp_sh_s;

   // Next-state and counter sequencing; the counter restarts on every state change.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r + CNT_ONE;
      accept_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cnt_s = CNT_ZERO;
            if (bus.start) begin
               accept_s = 1'b1;
               state_s  = ST_LOAD;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (cnt_r == SHIFT_END) begin
               state_s = ST_CAPTURE;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = ST_LOAD;
            end
         end
         ST_CAPTURE: begin
            if (cnt_r == CAP_END) begin
               state_s = ST_UNLOAD;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = ST_CAPTURE;
            end
         end
         ST_UNLOAD: begin
            if (cnt_r == SHIFT_END) begin
               state_s = ST_FINISH;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = ST_UNLOAD;
            end
         end
         ST_FINISH: begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
         end
      endcase
   end

   // Scan-in bit for the coming cycle: MSB first, taken from the pattern being latched on entry.
   always_comb begin
      pat_d_s   = accept_s ? bus.pat : pat_q_r;
      pat_sh_s  = pat_d_s << cnt_s;
      si_s      = (state_s == ST_LOAD) ? pat_sh_s[CHAIN_LEN-1] : 1'b0;
      resp_sh_s = {resp_r[CHAIN_LEN-2:0], bus.so};
   end

   // State, counter and the output decode, registered from the next-state values.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         se_r    <= 1'b0;
         si_r    <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         se_r    <= (state_s == ST_LOAD) || (state_s == ST_UNLOAD);
         si_r    <= si_s;
         busy_r  <= (state_s != ST_IDLE);
         done_r  <= (state_s == ST_FINISH);
      end
   end

   // Pattern/expect latches, response shift register and the compare result.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         pat_q_r    <= {CHAIN_LEN{1'b0}};
         exp_q_r    <= {CHAIN_LEN{1'b0}};
         resp_r     <= {CHAIN_LEN{1'b0}};
         mismatch_r <= 1'b0;
      end else begin
         if (accept_s) begin
            pat_q_r <= bus.pat;
            exp_q_r <= bus.exp;
         end else begin
            pat_q_r <= pat_q_r;
            exp_q_r <= exp_q_r;
         end
         if ((state_r == ST_CAPTURE) && (state_s == ST_UNLOAD)) begin
            resp_r     <= {CHAIN_LEN{1'b0}};
            mismatch_r <= 1'b0;
         end else if (state_r == ST_UNLOAD) begin
            resp_r     <= resp_sh_s;
            mismatch_r <= (state_s == ST_FINISH) ? (resp_sh_s != exp_q_r) : mismatch_r;
         end else begin
            resp_r     <= resp_r;
            mismatch_r <= mismatch_r;
         end
      end
   end

   assign bus.se       = se_r;
   assign bus.si       = si_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.resp     = resp_r;
   assign bus.mismatch = mismatch_r;

endmodule
